sync_handshake_tx: RTL and testbench

//   Source-side launcher of a toggle req/ack CDC handshake; the counterpart to the

---
 rtl/sync_handshake_tx.sv | 118 +++++++++++
 tb/tb_sync_handshake_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_handshake_tx.sv
// Source-side launcher of a toggle req/ack CDC handshake.
// Captures one word per transfer, holds it on xfer_data, toggles xfer_req and
// waits for the returned ack toggle after a C_SYNC_STAGE-deep synchronizer.
module sync_handshake_tx #(
  parameter int C_SYNC_STAGE = 2,
  parameter int C_DW         = 4,
  parameter int C_TIMEOUT    = 0,
  parameter int pTCQ         = 100
) (
  input  logic            src_clk,
  input  logic            src_rst,
  input  logic            src_valid,
  output logic            src_ready,
  input  logic [C_DW-1:0] src_data,
  output logic            src_done,
  output logic            xfer_req,
  output logic [C_DW-1:0] xfer_data,
  input  logic            xfer_ack,
  output logic            timeout_err,
  input  logic            timeout_clr
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam bit          TO_EN   = (C_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(C_TIMEOUT - 1) : 16'd0;

  // Elaboration-time parameter sanity; pTCQ is kept only for interface
  // compatibility with the original model and has no effect on the logic.
  if (C_SYNC_STAGE < 2 || C_DW < 1 || C_TIMEOUT < 0 || C_TIMEOUT > 65535 || pTCQ < 0)
  begin : g_bad_param
    $error("sync_handshake_tx: illegal parameter value");
  end

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [C_DW-1:0]   data_q, data_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ack_s;

  (* async_reg = "true" *) logic [C_SYNC_STAGE-1:0] ack_sync_q;

  // Ack synchronizer: xfer_ack is asynchronous to src_clk.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) ack_sync_q <= '0;
    else         ack_sync_q <= {ack_sync_q[C_SYNC_STAGE-2:0], xfer_ack};
  end

  assign ack_s = ack_sync_q[C_SYNC_STAGE-1];

  // Handshake state and output registers.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a timeout set event overrides a concurrent clear.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (timeout_clr) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (src_valid && ready_q) begin
          data_d  = src_data;
          req_d   = ~req_q;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
        if (TO_EN && (cnt_q == TO_LAST)) err_d = 1'b1;
        if (ack_s == req_q) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign src_ready   = ready_q;
  assign src_done    = done_q;
  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_sync_handshake_tx.sv
// Directed bench for sync_handshake_tx (C_SYNC_STAGE=2, C_DW=4, C_TIMEOUT=8).
module tb_sync_handshake_tx;

  logic       src_clk = 1'b0;
  logic       src_rst;
  logic       src_valid;
  logic       src_ready;
  logic [3:0] src_data;
  logic       src_done;
  logic       xfer_req;
  logic [3:0] xfer_data;
  logic       xfer_ack;
  logic       timeout_err;
  logic       timeout_clr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        exp_req  = 1'b0;

  sync_handshake_tx #(
    .C_SYNC_STAGE(2),
    .C_DW        (4),
    .C_TIMEOUT   (8),
    .pTCQ        (100)
  ) dut (
    .src_clk    (src_clk),
    .src_rst    (src_rst),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .src_done   (src_done),
    .xfer_req   (xfer_req),
    .xfer_data  (xfer_data),
    .xfer_ack   (xfer_ack),
    .timeout_err(timeout_err),
    .timeout_clr(timeout_clr)
  );

  always #5 src_clk = ~src_clk;

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Bounded wait for src_done after an ack toggle; checks latency and ready.
  task automatic wait_done(input string tag, input int unsigned max_edges,
                           input int unsigned exp_edges);
    int unsigned n = 0;
    bit seen = 1'b0;
    while (!seen && n < max_edges) begin
      tick();
      n++;
      if (src_done === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, n, exp_edges);
    check({tag, "_ready"}, 32'(src_ready), 32'd1);
  endtask

  initial begin
    src_rst     = 1'b1;
    src_valid   = 1'b0;
    src_data    = 4'h0;
    xfer_ack    = 1'b0;
    timeout_clr = 1'b0;

    // 1: reset held three cycles
    repeat (3) tick();
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_done", 32'(src_done), 32'd0);
    check("rst_req", 32'(xfer_req), 32'd0);
    check("rst_data", 32'(xfer_data), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    src_rst = 1'b0;
    #1;
    check("rel_ready_before_edge", 32'(src_ready), 32'd0);
    tick();
    check("rel_ready", 32'(src_ready), 32'd1);

    // 2: single transfer of 4'hA
    src_valid = 1'b1;
    src_data  = 4'hA;
    tick();
    exp_req = ~exp_req;
    src_valid = 1'b0;
    check("single_data", 32'(xfer_data), 32'hA);
    check("single_req", 32'(xfer_req), 32'(exp_req));
    check("single_ready0", 32'(src_ready), 32'd0);
    xfer_ack = exp_req;
    wait_done("single_done", 6, 3);
    tick();
    check("single_pulse", 32'(src_done), 32'd0);
    check("single_ready1", 32'(src_ready), 32'd1);

    // 3: back-to-back with valid held, ack echoed after 4 cycles
    src_valid = 1'b1;
    src_data  = 4'h1;
    for (int w = 1; w <= 3; w++) begin
      tick();
      exp_req = ~exp_req;
      check("b2b_data", 32'(xfer_data), 32'(w));
      check("b2b_req", 32'(xfer_req), 32'(exp_req));
      check("b2b_ready0", 32'(src_ready), 32'd0);
      check("b2b_pulse", 32'(src_done), 32'd0);
      src_data = 4'(w + 1);
      repeat (4) tick();
      xfer_ack = exp_req;
      wait_done("b2b_done", 6, 3);
    end
    src_valid = 1'b0;
    check("b2b_no_err", 32'(timeout_err), 32'd0);

    // 4: src_data churn while busy
    tick();
    src_valid = 1'b1;
    src_data  = 4'h5;
    tick();
    exp_req = ~exp_req;
    for (int i = 0; i < 4; i++) begin
      src_data = 4'($urandom);
      tick();
      check("busy_data", 32'(xfer_data), 32'h5);
      check("busy_req", 32'(xfer_req), 32'(exp_req));
      check("busy_ready", 32'(src_ready), 32'd0);
    end
    src_valid = 1'b0;
    xfer_ack  = exp_req;
    wait_done("busy_done", 6, 3);
    tick();

    // 5: timeout after 8 WAIT_ACK cycles, late ack, clear
    src_valid = 1'b1;
    src_data  = 4'h6;
    tick();
    exp_req = ~exp_req;
    src_valid = 1'b0;
    repeat (7) tick();
    check("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("to_set", 32'(timeout_err), 32'd1);
    repeat (3) tick();
    check("to_sticky", 32'(timeout_err), 32'd1);
    check("to_still_busy", 32'(src_ready), 32'd0);
    xfer_ack = exp_req;
    wait_done("to_late_done", 6, 3);
    check("to_after_done", 32'(timeout_err), 32'd1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("to_clr", 32'(timeout_err), 32'd0);

    // 6: reset in the middle of WAIT_ACK with xfer_req=1
    src_valid = 1'b1;
    src_data  = 4'h7;
    tick();
    exp_req = ~exp_req;
    src_valid = 1'b0;
    check("mid_req1", 32'(xfer_req), 32'd1);
    repeat (2) tick();
    src_rst = 1'b1;
    #1;
    exp_req = 1'b0;
    check("mid_req0", 32'(xfer_req), 32'd0);
    check("mid_ready0", 32'(src_ready), 32'd0);
    check("mid_data0", 32'(xfer_data), 32'd0);
    check("mid_done0", 32'(src_done), 32'd0);
    repeat (2) tick();
    src_rst = 1'b0;
    tick();
    check("mid_ready1", 32'(src_ready), 32'd1);
    check("mid_no_done", 32'(src_done), 32'd0);
    tick();
    check("mid_no_done2", 32'(src_done), 32'd0);

    // Set and clear in the same cycle: set wins, then clear takes effect
    timeout_clr = 1'b1;
    src_valid   = 1'b1;
    src_data    = 4'h9;
    tick();
    exp_req = ~exp_req;
    src_valid = 1'b0;
    check("race_data", 32'(xfer_data), 32'h9);
    repeat (7) tick();
    check("race_before", 32'(timeout_err), 32'd0);
    tick();
    check("race_set_wins", 32'(timeout_err), 32'd1);
    tick();
    check("race_clr", 32'(timeout_err), 32'd0);
    timeout_clr = 1'b0;
    xfer_ack = exp_req;
    wait_done("race_done", 6, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
